mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: fetch requester, data requester and memory side.
// The arbiter connects through the slave modport; the requester/memory model uses master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin on collisions; otherwise data always wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                gnt_d;
  logic                we_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_ready_q;
  logic                d_ready_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic                busy_q;
  logic                grant_d_c;
  logic                any_req_c;

  assign any_req_c = bus.if_req || bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d: 1 when the previous grant went to the data port; reset favours fetch.
  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_d <= 1'b1;
    else if (state == IDLE && any_req_c)
      last_d <= grant_d_c;
  end

  assign grant_d_c = bus.d_req && (!bus.if_req || !last_d);
`else
  assign grant_d_c = bus.d_req;
`endif

  // Transaction FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_d      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            gnt_d <= grant_d_c;
            if (grant_d_c) begin
              addr_q  <= bus.d_addr;
              we_q    <= bus.d_we;
              wdata_q <= bus.d_wdata;
            end else begin
              addr_q  <= bus.if_addr;
              we_q    <= 1'b0;
            end
            mem_we_q <= grant_d_c && bus.d_we;
            cnt      <= CNT_W'(MEM_LATENCY - 1);
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            // Read data is only valid while mem_en is high, so capture on the last access cycle.
            if (!we_q) begin
              if (gnt_d) d_rdata_q  <= bus.mem_rdata;
              else       if_rdata_q <= bus.mem_rdata;
            end
            if (gnt_d) d_ready_q  <= 1'b1;
            else       if_ready_q <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state    <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-2 instance for most scenarios,
// latency-1 instance for back-to-back fetch throughput.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();

  mem_port_arbiter #(.MEM_LATENCY(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge: outputs settled, inputs safe to change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_d;

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
    tick(); tick();
    check("rst_mem_en",   bus.mem_en,   0);
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdat", bus.mem_wdata,0);
    check("rst_busy",     bus.busy,     0);
    check("rst_rdy",      {bus.if_ready, bus.d_ready}, 0);
    rst = 1'b0;
    tick();

    // Fetch at cycle 0, latency 2
    bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_rdata = 32'h2002_0005;
    tick();
    check("f_c1_en",   bus.mem_en,   1);
    check("f_c1_addr", bus.mem_addr, 32'h10);
    check("f_c1_we",   bus.mem_we,   0);
    check("f_c1_busy", bus.busy,     1);
    tick();
    check("f_c2_en",   bus.mem_en,   1);
    check("f_c2_rdy",  bus.if_ready, 0);
    tick();
    check("f_c3_rdy",  bus.if_ready, 1);
    check("f_c3_drdy", bus.d_ready,  0);
    check("f_c3_data", bus.if_rdata, 32'h2002_0005);
    check("f_c3_en",   bus.mem_en,   0);
    bus.if_req = 0;
    tick();
    check("f_c4_rdy",  bus.if_ready, 0);
    check("f_c4_busy", bus.busy,     0);
    check("f_c4_hold", bus.if_rdata, 32'h2002_0005);

    // Store: d_rdata must not pick up the memory bus
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    check("s_c1_we",   bus.mem_we,    1);
    check("s_c1_addr", bus.mem_addr,  32'h40);
    check("s_c1_wdat", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 32'hFFFF_FFFF; bus.d_wdata = 32'h0;
    tick();
    check("s_c2_we",   bus.mem_we,    1);
    check("s_c2_wdat", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("s_c3_drdy", bus.d_ready,   1);
    check("s_c3_irdy", bus.if_ready,  0);
    check("s_c3_rdat", bus.d_rdata,   0);
    check("s_c3_we",   bus.mem_we,    0);
    tick();
    check("s_c4_addr", bus.mem_addr,  32'h40);
    check("s_c4_wdat", bus.mem_wdata, 32'hDEAD_BEEF);
    check("s_c4_req0", bus.busy,      0);

    // Load on the data port
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80; bus.mem_rdata = 32'hCAFE_0001;
    repeat (3) tick();
    check("l_c3_drdy", bus.d_ready,  1);
    check("l_c3_rdat", bus.d_rdata,  32'hCAFE_0001);
    check("l_c3_ifd",  bus.if_rdata, 32'h2002_0005);
    bus.d_req = 0;
    tick();

    // Both requesters held: ready every 4 cycles, winner per arbitration mode
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.mem_rdata = 32'h0000_0A0A;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      check($sformatf("arb%0d_irdy", k), bus.if_ready, !exp_d);
      check($sformatf("arb%0d_drdy", k), bus.d_ready,  exp_d);
      check($sformatf("arb%0d_addr", k), bus.mem_addr, exp_d ? 32'h200 : 32'h100);
      if (k < 3) repeat (4) tick();
    end
    bus.if_req = 0; bus.d_req = 0;
    tick();
    check("arb_idle", bus.busy, 0);

    // Reset during the second ACCESS cycle
    bus.if_req = 1; bus.if_addr = 32'h30; bus.mem_rdata = 32'h5555_AAAA;
    tick(); tick();
    check("r_c2_en", bus.mem_en, 1);
    bus.if_req = 0;
    #2 rst = 1'b1;
    #1;
    check("r_en0",   bus.mem_en,   0);
    check("r_busy0", bus.busy,     0);
    tick();
    check("r_rdy0",  bus.if_ready, 0);
    check("r_rdat0", bus.if_rdata, 0);
    #2 rst = 1'b0;
    tick();
    check("r_after", bus.if_ready, 0);
    bus.if_req = 1; bus.if_addr = 32'h34; bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    check("r_n_addr", bus.mem_addr, 32'h34);
    tick(); tick();
    check("r_n_rdy",  bus.if_ready, 1);
    check("r_n_data", bus.if_rdata, 32'h0BAD_F00D);
    bus.if_req = 0;
    tick();

    // Latency 1: held fetch completes every 3 cycles
    bus1.if_req = 1; bus1.if_addr = 32'h8; bus1.mem_rdata = 32'h0000_0111;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("l1_c%0d_rdy", c), bus1.if_ready, (c % 3) == 2);
    end
    check("l1_data", bus1.if_rdata, 32'h0000_0111);
    bus1.if_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
